// File: rtl/mram_serial_ctrl_pkg.sv
// Shared types and helpers for the serial MRAM controller.
// State encoding, lane-enable decode and counter sizing.
package mram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_SEROUT,
    ST_DONE
  } state_e;

  // byte_sel of 00 selects both lanes
  function automatic logic [1:0] lane_en(
    input logic [1:0] bs
  );
    return (bs == 2'b00) ? 2'b11 : bs;
  endfunction

  // width of the shared down-counter
  function automatic int cnt_width(
    input int n,
    input int ts,
    input int ta,
    input int th
  );
    int m;
    m = n;
    if (ts > m) m = ts;
    if (ta > m) m = ta;
    if (th > m) m = th;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mram_serial_ctrl_shift_reg.sv
// Shift register: serial load LSB first, parallel load,
// and right shift so q_o[0] is the next serial bit out.
module mram_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic             ser_i,
  input  logic             load_en_i,
  input  logic [WIDTH-1:0] par_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // parallel load wins over shift; new serial bits enter at the MSB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            q_q <= '0;
    else if (load_en_i)  q_q <= par_i;
    else if (shift_en_i) q_q <= {ser_i, q_q[WIDTH-1:1]};
  end

  assign q_o = q_q;

endmodule

// File: rtl/mram_serial_ctrl.sv
// Serial-to-MRAM access controller with timed strobes and lanes.
// Optional readback check after writes: WRITE_VERIFY_EN.
module mram_serial_ctrl
  import mram_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int T_SETUP  = 1,
  parameter int T_ACCESS = 4,
  parameter int T_HOLD   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_valid,
  input  logic              addr_in,
  input  logic              data_in,
  input  logic              read_write_sel,
  input  logic [1:0]        byte_sel,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] parallel_data_in,
  output logic              chip_en,
  output logic              write_en,
  output logic              out_en,
  output logic              lower_byte_en,
  output logic              upper_byte_en,
  output logic              ser_data_out,
  output logic              ser_out_valid,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
  output logic              verify_err
);

  localparam int N =
    (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W =
    cnt_width(N, T_SETUP, T_ACCESS, T_HOLD);

  localparam logic [CNT_W-1:0] LD_SHIFT = CNT_W'(N - 2);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_ACC   = CNT_W'(T_ACCESS - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_SER   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

`ifdef WRITE_VERIFY_EN
  localparam logic VERIFY = 1'b1;
`else
  localparam logic VERIFY = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rw_q, rw_d;
  logic [1:0]       bsel_q, bsel_d;
  logic             vph_q, vph_d;
  logic             ferr_q, ferr_d;

  logic [CNT_W-1:0]  idx;
  logic              take, a_sh, d_sh, cap;
  logic              in_cyc, wr_ph;
  logic [DATA_W-1:0] mask, wd_q, rd_q;
  logic [ADDR_W-1:0] ad_q;

  assign mask = {{(DATA_W/2){bsel_q[1]}},
                 {(DATA_W/2){bsel_q[0]}}};

  // serial bit index; bits past a register's width are dropped
  assign idx  = (state_q == ST_IDLE) ? '0 : LAST_IDX - cnt_q;
  assign take = frame_valid &&
                (state_q == ST_IDLE || state_q == ST_SHIFT);
  assign a_sh = take && (idx < CNT_W'(ADDR_W));
  assign d_sh = take && (idx < CNT_W'(DATA_W));
  assign cap  = (state_q == ST_STROBE) && (cnt_q == '0) &&
                (!rw_q || vph_q);

  mram_shift_reg #(.WIDTH(ADDR_W)) u_addr (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (a_sh),
    .ser_i      (addr_in),
    .load_en_i  (1'b0),
    .par_i      ('0),
    .q_o        (ad_q)
  );

  mram_shift_reg #(.WIDTH(DATA_W)) u_wdata (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (d_sh),
    .ser_i      (data_in),
    .load_en_i  (1'b0),
    .par_i      ('0),
    .q_o        (wd_q)
  );

  mram_shift_reg #(.WIDTH(DATA_W)) u_rdata (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (state_q == ST_SEROUT),
    .ser_i      (1'b0),
    .load_en_i  (cap),
    .par_i      (parallel_data_in & mask),
    .q_o        (rd_q)
  );

  // state, shared counter and per-frame attributes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      bsel_q  <= 2'b11;
      vph_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      bsel_q  <= bsel_d;
      vph_q   <= vph_d;
      ferr_q  <= ferr_d;
    end
  end

  // next state; one down-counter times every phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 1'b1;
    rw_d    = rw_q;
    bsel_d  = bsel_q;
    vph_d   = vph_q;
    ferr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (frame_valid) begin
          state_d = ST_SHIFT;
          cnt_d   = LD_SHIFT;
          rw_d    = read_write_sel;
          bsel_d  = lane_en(byte_sel);
          vph_d   = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (!frame_valid) begin
          state_d = ST_IDLE;
          ferr_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_SETUP;
          cnt_d   = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = LD_ACC;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          if (!rw_q) begin
            state_d = ST_SEROUT;
            cnt_d   = LD_SER;
          end else if (VERIFY && !vph_q) begin
            state_d = ST_SETUP;
            cnt_d   = LD_SETUP;
            vph_d   = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SEROUT: begin
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_cyc = (state_q == ST_SETUP) ||
                  (state_q == ST_STROBE) ||
                  (state_q == ST_HOLD);
  assign wr_ph  = rw_q && !vph_q;

  assign addr_out      = ad_q;
  assign data_out      = wd_q;
  assign chip_en       = !in_cyc;
  assign write_en      = !((state_q == ST_STROBE) && wr_ph);
  assign out_en        = !((state_q == ST_STROBE) && !wr_ph);
  assign data_oe       = in_cyc && wr_ph;
  assign lower_byte_en = !(in_cyc && bsel_q[0]);
  assign upper_byte_en = !(in_cyc && bsel_q[1]);
  assign ser_out_valid = (state_q == ST_SEROUT);
  assign ser_data_out  = (state_q == ST_SEROUT) && rd_q[0];
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign frame_err     = ferr_q;

`ifdef WRITE_VERIFY_EN
  logic vfail_q;

  // compare masked readback against masked write data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      vfail_q <= 1'b0;
    else if (state_q == ST_IDLE)
      vfail_q <= 1'b0;
    else if (state_q == ST_HOLD && vph_q)
      vfail_q <= (rd_q != (wd_q & mask));
  end

  assign verify_err = (state_q == ST_DONE) && vfail_q;
`else
  logic unused_rd;

  // upper read bits only leave through the serial shift
  assign unused_rd  = ^rd_q[DATA_W-1:1];
  assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_mram_serial_ctrl.sv
// Directed bench for mram_serial_ctrl (default parameters).
// Optional readback checks when WRITE_VERIFY_EN is defined.
module tb_mram_serial_ctrl;

`ifdef WRITE_VERIFY_EN
  localparam int WR_DONE = 33;
  localparam int WR_CE   = 12;
  localparam int WR_OE   = 4;
`else
  localparam int WR_DONE = 27;
  localparam int WR_CE   = 6;
  localparam int WR_OE   = 0;
`endif
  localparam int RD_DONE = 43;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fv = 1'b0, ai = 1'b0, di = 1'b0, rws = 1'b0;
  logic [1:0]  bs = 2'b00;
  logic [15:0] pdi = '0;
  logic [19:0] addr_out;
  logic [15:0] data_out;
  logic        data_oe, ce, we, oe, lbe, ube;
  logic        sdo, sov, busy, done, ferr, verr;

  int n_chk = 0, n_pass = 0;
  int edges, n_ce, n_we, n_oe, n_doe, n_lo, n_up;
  int n_ser, n_done, n_ferr, n_stab, ce_first, we_first;
  int done_at, n_viol = 0;
  logic        ver, run = 1'b0;
  logic [15:0] ser_w;
  logic [19:0] exp_a;
  logic [15:0] exp_d;

  always #5 clk = ~clk;

  mram_serial_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .frame_valid      (fv),
    .addr_in          (ai),
    .data_in          (di),
    .read_write_sel   (rws),
    .byte_sel         (bs),
    .addr_out         (addr_out),
    .data_out         (data_out),
    .data_oe          (data_oe),
    .parallel_data_in (pdi),
    .chip_en          (ce),
    .write_en         (we),
    .out_en           (oe),
    .lower_byte_en    (lbe),
    .upper_byte_en    (ube),
    .ser_data_out     (sdo),
    .ser_out_valid    (sov),
    .busy             (busy),
    .done             (done),
    .frame_err        (ferr),
    .verify_err       (verr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  always @(posedge clk) if (run) edges++;

  always @(negedge clk) begin
    if (!we && !oe) n_viol++;
    if (data_oe && !oe) n_viol++;
    if (run) begin
      if (!ce) begin
        n_ce++;
        if (ce_first == 0) ce_first = edges + 1;
        if (addr_out !== exp_a) n_stab++;
      end
      if (!we) begin
        n_we++;
        if (we_first == 0) we_first = edges + 1;
        if (data_out !== exp_d) n_stab++;
      end
      if (!oe) n_oe++;
      if (data_oe) n_doe++;
      if (!lbe) n_lo++;
      if (!ube) n_up++;
      if (sov) begin
        if (n_ser < 16) ser_w[n_ser] = sdo;
        n_ser++;
      end
      if (done) begin
        n_done++;
        done_at = edges + 1;
        ver = verr;
      end
      if (ferr) n_ferr++;
    end
  end

  task automatic clear_mon();
    edges = 0; n_ce = 0; n_we = 0; n_oe = 0; n_doe = 0;
    n_lo = 0; n_up = 0; n_ser = 0; n_done = 0; n_ferr = 0;
    n_stab = 0; ce_first = 0; we_first = 0; done_at = 0;
    ver = 1'b0; ser_w = '0; run = 1'b1;
  endtask

  task automatic send(input logic rw, input logic [1:0] b,
                      input logic [19:0] a,
                      input logic [15:0] d,
                      input int nbits);
    logic [19:0] d20;
    d20 = {4'h0, d};
    exp_a = a;
    exp_d = d;
    clear_mon();
    for (int i = 0; i < nbits; i++) begin
      fv = 1'b1; rws = rw; bs = b;
      ai = a[i]; di = d20[i];
      @(posedge clk); #1;
    end
    fv = 1'b0; ai = 1'b0; di = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_done == 0)
      $display("FAIL %s_timeout: got no done in %0d cycles",
               tag, budget);
    chk({tag, "_done_cnt"}, n_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    #12;
    chk("rst_strobes", {ce, we, oe, lbe, ube}, 5'b11111);
    chk("rst_status", {data_oe, busy, done, ferr, verr}, 0);
    chk("rst_addr", addr_out, 0);
    chk("rst_data", data_out, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // write, both lanes
    pdi = 16'h03FF;
    send(1'b1, 2'b11, 20'h003FF, 16'h03FF, 20);
    wait_done("wr", 100);
    chk("wr_done_at", done_at, WR_DONE);
    chk("wr_ce_first", ce_first, 21);
    chk("wr_we_first", we_first, 22);
    chk("wr_we_cycles", n_we, 4);
    chk("wr_ce_cycles", n_ce, WR_CE);
    chk("wr_oe_cycles", n_oe, WR_OE);
    chk("wr_doe_cycles", n_doe, 6);
    chk("wr_stable", n_stab, 0);
    chk("wr_verify_err", ver, 0);
    chk("wr_busy_after", busy, 0);

    // read, both lanes
    pdi = 16'h5555;
    send(1'b0, 2'b11, 20'hAAAAA, 16'h0000, 20);
    wait_done("rd", 100);
    chk("rd_done_at", done_at, RD_DONE);
    chk("rd_oe_cycles", n_oe, 4);
    chk("rd_we_cycles", n_we, 0);
    chk("rd_doe_cycles", n_doe, 0);
    chk("rd_ser_bits", n_ser, 16);
    chk("rd_ser_word", ser_w, 16'h5555);
    chk("rd_addr_stable", n_stab, 0);

    // read, lower lane only
    pdi = 16'hBEEF;
    send(1'b0, 2'b01, 20'h12345, 16'h0000, 20);
    wait_done("lane", 100);
    chk("lane_ser_word", ser_w, 16'h00EF);
    chk("lane_lo_cycles", n_lo, 6);
    chk("lane_up_cycles", n_up, 0);

    // byte_sel 00 means both lanes
    send(1'b0, 2'b00, 20'h00F0F, 16'h0000, 20);
    wait_done("bs00", 100);
    chk("bs00_ser_word", ser_w, 16'hBEEF);
    chk("bs00_up_cycles", n_up, 6);

    // aborted frame after 7 bits
    send(1'b1, 2'b11, 20'hFFFFF, 16'hFFFF, 7);
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_ferr", n_ferr, 1);
    chk("abort_ce", n_ce, 0);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", n_done, 0);

    // next full frame runs normally
    pdi = 16'h0A5A;
    send(1'b1, 2'b11, 20'h5A5A5, 16'h0A5A, 20);
    wait_done("post", 100);
    chk("post_done_at", done_at, WR_DONE);
    chk("post_stable", n_stab, 0);

    // asynchronous reset in the middle of the write strobe
    send(1'b1, 2'b11, 20'h11111, 16'h1111, 20);
    k = 0;
    while (we !== 1'b0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rm_we_seen", we, 0);
    #2 rst = 1'b0;
    #1;
    chk("rm_strobes", {ce, we, oe, lbe, ube}, 5'b11111);
    chk("rm_status", {data_oe, busy}, 0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    pdi = 16'h3C3C;
    send(1'b0, 2'b11, 20'h22222, 16'h0000, 20);
    wait_done("rm_rd", 100);
    chk("rm_rd_done_at", done_at, RD_DONE);
    chk("rm_rd_word", ser_w, 16'h3C3C);

`ifdef WRITE_VERIFY_EN
    pdi = 16'h1235;
    send(1'b1, 2'b11, 20'h00100, 16'h1234, 20);
    wait_done("vf_bad", 100);
    chk("vf_bad_err", ver, 1);
    pdi = 16'h1234;
    send(1'b1, 2'b11, 20'h00100, 16'h1234, 20);
    wait_done("vf_ok", 100);
    chk("vf_ok_err", ver, 0);
    pdi = 16'h1235;
    send(1'b1, 2'b10, 20'h00100, 16'h1234, 20);
    wait_done("vf_up", 100);
    chk("vf_upper_only_err", ver, 0);
`endif

    chk("no_strobe_overlap", n_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
